// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Register scoreboard for the dual-issue pipeline. Counts outstanding
//   writers per architectural register and remembers whether the newest
//   pending writer is a load, then derives the issue hazards for the
//   current decode pair.
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   rs1_N, rs2_N, rd_N    slot N register indices (N = 0, 1)
//   use_rs1_N, use_rs2_N  slot N reads the corresponding source
//   reg_write_N           slot N writes rd_N
//   mem_read_N            slot N is a load
//   fire0, fire1          slot actually dispatched this cycle
//   wbK_valid/_rd/_is_load writeback port K retires a write to wbK_rd
//   sb_clear              drop all tracking state (pipeline restart)
//   raw_hazard1           slot1 source depends on slot0 rd or a pending reg
//   waw_hazard1           slot1 rd collides with slot0 rd or a pending reg
//   load_use0/1           slot source reads a register with a pending load
//   busy_mask             bit r set while register r has a pending writer
//   sb_err                sticky counter overflow/underflow flag
module issue_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_0,
  input  logic [4:0]  rs2_0,
  input  logic [4:0]  rd_0,
  input  logic        use_rs1_0,
  input  logic        use_rs2_0,
  input  logic        reg_write_0,
  input  logic        mem_read_0,
  input  logic [4:0]  rs1_1,
  input  logic [4:0]  rs2_1,
  input  logic [4:0]  rd_1,
  input  logic        use_rs1_1,
  input  logic        use_rs2_1,
  input  logic        reg_write_1,
  input  logic        mem_read_1,
  input  logic        fire0,
  input  logic        fire1,
  input  logic        wb0_valid,
  input  logic        wb1_valid,
  input  logic [4:0]  wb0_rd,
  input  logic [4:0]  wb1_rd,
  input  logic        wb0_is_load,
  input  logic        wb1_is_load,
  input  logic        sb_clear,
  output logic        raw_hazard1,
  output logic        waw_hazard1,
  output logic        load_use0,
  output logic        load_use1,
  output logic [31:0] busy_mask,
  output logic        sb_err
);

  localparam logic signed [CNT_W+1:0] CNT_MAX = $signed({2'b00, {CNT_W{1'b1}}});

  // x0 carries no state, so storage covers registers 1..31 only.
  logic [CNT_W-1:0] cnt_q   [1:31];
  logic [CNT_W-1:0] cnt_nxt [1:31];
  logic [31:1]      ld_q;
  logic [31:1]      ld_nxt;
  logic             err_nxt;
  logic [31:0]      ld_vec;
  logic             w0;
  logic             w1;
  logic             src1_hits_rd0;

  // Counter update with saturation. Returns {error, clamped count}.
  function automatic logic [CNT_W:0] sat_update(input logic [CNT_W-1:0] cur,
                                                input logic [1:0]       inc,
                                                input logic [1:0]       dec);
    logic signed [CNT_W+1:0] sum;
    sum = $signed({2'b00, cur}) + $signed({{CNT_W{1'b0}}, inc})
        - $signed({{CNT_W{1'b0}}, dec});
    if (sum[CNT_W+1])
      return {1'b1, {CNT_W{1'b0}}};
    else if (sum > CNT_MAX)
      return {1'b1, {CNT_W{1'b1}}};
    else
      return {1'b0, sum[CNT_W-1:0]};
  endfunction

  assign w0 = fire0 && reg_write_0 && (rd_0 != 5'd0);
  assign w1 = fire1 && reg_write_1 && (rd_1 != 5'd0);

  always_comb begin
    logic [1:0]       inc;
    logic [1:0]       dec;
    logic [CNT_W:0]   upd;
    logic [4:0]       r5;
    err_nxt = sb_err;
    for (int r = 1; r < 32; r++) begin
      r5  = 5'(r);
      inc = {1'b0, w0 && (rd_0 == r5)} + {1'b0, w1 && (rd_1 == r5)};
      dec = {1'b0, wb0_valid && (wb0_rd == r5)} + {1'b0, wb1_valid && (wb1_rd == r5)};
      upd = sat_update(cnt_q[r], inc, dec);
      cnt_nxt[r] = upd[CNT_W-1:0];
      err_nxt    = err_nxt | upd[CNT_W];
      // A new load writer outranks a retiring load in the same cycle.
      if ((w0 && mem_read_0 && (rd_0 == r5)) || (w1 && mem_read_1 && (rd_1 == r5)))
        ld_nxt[r] = 1'b1;
      else if ((wb0_valid && wb0_is_load && (wb0_rd == r5)) ||
               (wb1_valid && wb1_is_load && (wb1_rd == r5)))
        ld_nxt[r] = 1'b0;
      else
        ld_nxt[r] = ld_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      ld_q   <= '0;
      sb_err <= 1'b0;
    end else if (sb_clear) begin
      // Same-cycle fires and writebacks are dropped, including their errors.
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      ld_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_nxt[r];
      ld_q   <= ld_nxt;
      sb_err <= err_nxt;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) busy_mask[r] = |cnt_q[r];
  end

  // Bit 0 of both vectors is constant zero, so indexing by a source of x0
  // never produces a hazard.
  assign ld_vec = {ld_q, 1'b0};

  assign src1_hits_rd0 = (rd_0 != 5'd0) &&
                         ((use_rs1_1 && (rs1_1 == rd_0)) || (use_rs2_1 && (rs2_1 == rd_0)));

  assign raw_hazard1 = (use_rs1_1 && busy_mask[rs1_1]) ||
                       (use_rs2_1 && busy_mask[rs2_1]) ||
                       (reg_write_0 && src1_hits_rd0);

  assign waw_hazard1 = reg_write_1 && (rd_1 != 5'd0) &&
                       (busy_mask[rd_1] || (reg_write_0 && (rd_1 == rd_0)));

  assign load_use0 = (use_rs1_0 && ld_vec[rs1_0]) || (use_rs2_0 && ld_vec[rs2_0]);

  assign load_use1 = (use_rs1_1 && ld_vec[rs1_1]) || (use_rs2_1 && ld_vec[rs2_1]) ||
                     (mem_read_0 && reg_write_0 && src1_hits_rd0);

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register scoreboard for the Stage-3 dual-issue pipeline. Tracks outstanding writes to each architectural register from instructions already dispatched. Produces the hazard flags consumed by the issue unit: slot1 RAW/WAW, and slot0/slot1 load-use. Sits beside decode: issue fire and decode metadata come in, and writeback retirements clear entries.

## Interface
Parameters:
- CNT_W, 2, width of the per-register outstanding-writer counter (saturates at 2^CNT_W-1)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rs1_0, rs2_0, rd_0  in  5 each  slot0 source/destination register indices
- use_rs1_0, use_rs2_0, reg_write_0, mem_read_0  in  1 each  slot0 operand-use, writes-rd, is-load flags
- rs1_1, rs2_1, rd_1, use_rs1_1, use_rs2_1, reg_write_1, mem_read_1  in  5/5/5/1/1/1/1  same fields for slot1
- fire0, fire1  in  1 each  slot actually dispatched this cycle (issue decision qualified by stall)
- wb0_valid, wb1_valid  in  1 each  writeback port retires a register write
- wb0_rd, wb1_rd  in  5 each  retired destination
- wb0_is_load, wb1_is_load  in  1 each  retired write was a load
- sb_clear  in  1  synchronous clear of all tracking state (pipeline restart)
- raw_hazard1  out  1  slot1 source depends on slot0 rd or on a pending register
- waw_hazard1  out  1  slot1 rd equals slot0 rd or a pending register
- load_use0, load_use1  out  1 each  slot source reads a register with an outstanding load
- busy_mask  out  32  bit r = register r has at least one outstanding writer
- sb_err  out  1  sticky: counter overflow or underflow occurred

## Operation
- State per register r (1..31): cnt[r] (CNT_W bits), ld[r] (1 bit). r=0 is hard-wired to cnt=0, ld=0. x0 never sets state, never raises a hazard, and is ignored on writeback.
- Effective write: wN = fireN && reg_write_N && rd_N!=0.
- Counter update per cycle: cnt_next = cnt + inc − dec.
  - inc ∈ {0,1,2}: count of effective writes to r.
  - dec ∈ {0,1,2}: count of wbK_valid with wbK_rd==r.
  - Arithmetic is done in CNT_W+2 bits.
  - Result > max: clamp to max and set sb_err.
  - Result < 0: clamp to 0 and set sb_err.
- ld[r] update:
  - Set when an effective write to r has mem_read.
  - Cleared when a writeback to r has wbK_is_load.
  - Set and clear in the same cycle: set wins.
- Hazards are combinational from registered state plus current decode fields. A same-cycle writeback does not remove a hazard.
  - pend(x) = cnt[x]!=0.
  - src1 matches x = (use_rs1_1 && rs1_1==x) || (use_rs2_1 && rs2_1==x), with x!=0.
  - raw_hazard1 = src1 matches any pending x, OR (reg_write_0 && rd_0!=0 && src1 matches rd_0).
  - waw_hazard1 = reg_write_1 && rd_1!=0 && (pend(rd_1) || (reg_write_0 && rd_1==rd_0)).
  - load_use0 = a used slot0 source x!=0 has ld[x].
  - load_use1 = a used slot1 source x!=0 has ld[x], OR (mem_read_0 && reg_write_0 && src1 matches rd_0).
- Hazards do not depend on fire0/fire1. They describe the current decode pair.
- busy_mask[r] = pend(r); busy_mask[0] = 0.
- sb_clear zeroes all cnt and ld; sb_err is kept. Any fires or writebacks in the same cycle are discarded.

## Timing
- Reset (rst=1 at a clk edge): all cnt=0, all ld=0, sb_err=0. Hazard outputs are then 0 for any decode input except the intra-pair terms. busy_mask=0.
- State changes take effect on the edge after fire/wb. Hazards see the new state in the next cycle (1-cycle latency).
- rst has priority over sb_clear. Reset mid-operation drops all pending entries with no errors.
- Simultaneous fire0 and fire1 to the same rd (only possible if the issue unit ignored waw) gives inc=2.

## Test plan
- Reset, then decode slot0 x5=x1+x2 and slot1 x6=x5+x3 with no fire → raw_hazard1=1, waw_hazard1=0, load_use*=0, busy_mask=0.
- fire0 of lw x7 → next cycle busy_mask[7]=1. Then slot0 rs1=x7 → load_use0=1. wb0_valid rd=7 is_load → the following cycle load_use0=0 and busy_mask[7]=0.
- fire0 and fire1 writing x9 and x10, then wb0 rd=9 and wb1 rd=10 in the same cycle → both counters go 1→0 and busy_mask=0.
- Issue x4 three times (cnt=3), then a 4th write with CNT_W=2 → cnt stays 3 and sb_err=1 (sticky). A writeback to empty x8 also sets sb_err.
- Any writes or reads naming x0 → no busy bit, no hazard, cnt[0] stays 0.
- sb_clear with x12 pending and a concurrent fire to x13 → next cycle busy_mask=0; sb_err unchanged.
